// File: rtl/cskip_pkg.sv
// ---------------------------------------------------------------------------
// cskip_pkg
// Shared sizing helpers for the pipelined carry-skip adder.
//   cskip_nblocks    : number of skip blocks across the operand
//   cskip_bps        : skip blocks handled by each pipeline stage
//   cskip_params_ok  : legality of a WIDTH/BLOCK/STAGES combination
// The helpers return 0 rather than dividing by zero, so an illegal
// parameter set reaches the top-level elaboration check and stops there.
// ---------------------------------------------------------------------------
package cskip_pkg;

    function automatic int cskip_nblocks(input int width, input int block);
        return (block > 0) ? width / block : 0;
    endfunction

    function automatic int cskip_bps(input int width, input int block, input int stages);
        return (stages > 0) ? cskip_nblocks(width, block) / stages : 0;
    endfunction

    // The operand must split into whole blocks.
    // Every stage must process the same whole number of blocks.
    function automatic bit cskip_params_ok(input int width, input int block, input int stages);
        if (width < 1 || block < 1 || stages < 1)
            return 1'b0;
        if ((width % block) != 0)
            return 1'b0;
        if ((cskip_nblocks(width, block) % stages) != 0)
            return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/cskip_block.sv
// ---------------------------------------------------------------------------
// cskip_block
// Combinational BLOCK-bit carry-skip cell. The cell ripples its carry
// internally. If every bit position propagates, the block carry-in is
// forwarded directly to co, so that the critical path skips the ripple.
// Ports:
//   a, b : block operand slices
//   ci   : block carry-in
//   s    : block sum slice
//   co   : block carry-out (skip mux output)
// ---------------------------------------------------------------------------
module cskip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co
);

    logic [BLOCK-1:0] p;
    logic             rco;

    assign p = a ^ b;

    // Plain ripple through the block; rco is the slow ripple carry-out.
    always_comb begin
        logic c;
        c   = ci;
        s   = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = p[i] ^ c;
            c    = (a[i] & b[i]) | (p[i] & c);
        end
        rco = c;
    end

    // A fully propagating block passes ci through unchanged.
    // This matches rco logically, but it gives the short path.
    assign co = (&p) ? ci : rco;

endmodule

// File: rtl/cskip_adder_pipe.sv
// ---------------------------------------------------------------------------
// cskip_adder_pipe
// Pipelined, parametrised carry-skip adder with valid/ready handshake.
// {cout,sum} = a + b + cin.
// Each of the STAGES stages adds the next slice of BPS*BLOCK bits. It then
// registers the partial sum, the carry, the still-unprocessed upper operand
// bits and the valid bit. The last register is the output register, so the
// latency is STAGES cycles.
// A single global enable advances or freezes every register together.
// Bubbles are not collapsed.
// Optional: define CSKIP_OVF_EN to add the registered signed-overflow
// output ovf.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake
//   sum, cout           : result
//   ovf                 : signed overflow (CSKIP_OVF_EN only)
// ---------------------------------------------------------------------------
module cskip_adder_pipe
    import cskip_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSKIP_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NB  = cskip_nblocks(WIDTH, BLOCK);
    localparam int BPS = cskip_bps(WIDTH, BLOCK, STAGES);
    localparam int SW  = BPS * BLOCK;    // bits summed per stage

    if (!cskip_params_ok(WIDTH, BLOCK, STAGES)) begin : g_param_err
        $fatal(1, "cskip_adder_pipe: WIDTH=%0d must be a multiple of BLOCK=%0d and NB=%0d a multiple of STAGES=%0d",
               WIDTH, BLOCK, NB, STAGES);
    end

    logic en;

    // The whole pipe moves when the output slot is empty or being drained.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int RW = WIDTH - s * SW;    // operand bits still to add
        localparam int PW = (s + 1) * SW;      // sum bits known after this stage

        logic [RW-1:0] ia, ib;
        logic          ic, iv;
        logic [SW-1:0] res;
        logic [BPS:0]  bc;
        logic [PW-1:0] nps;
        logic          rv, rc;
        logic [PW-1:0] rps;

        // Stage 0 works straight from the ports.
        // Later stages work from the previous register.
        if (s == 0) begin : g_in
            assign ia  = a;
            assign ib  = b;
            assign ic  = cin;
            assign iv  = in_valid;
            assign nps = res;
        end else begin : g_in
            assign ia  = g_stage[s-1].g_fwd.ra;
            assign ib  = g_stage[s-1].g_fwd.rb;
            assign ic  = g_stage[s-1].rc;
            assign iv  = g_stage[s-1].rv;
            assign nps = {res, g_stage[s-1].rps};
        end

        assign bc[0] = ic;

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            cskip_block #(.BLOCK(BLOCK)) u_blk (
                .a  (ia[j*BLOCK +: BLOCK]),
                .b  (ib[j*BLOCK +: BLOCK]),
                .ci (bc[j]),
                .s  (res[j*BLOCK +: BLOCK]),
                .co (bc[j+1])
            );
        end

        // Stage register: valid, carry and the partial sum accumulated so far.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rv  <= 1'b0;
                rc  <= 1'b0;
                rps <= '0;
            end else if (en) begin
                rv  <= iv;
                rc  <= bc[BPS];
                rps <= nps;
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [RW-SW-1:0] ra, rb;

            // Only the operand bits that later stages still need are carried forward.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ra <= '0;
                    rb <= '0;
                end else if (en) begin
                    ra <= ia[RW-1:SW];
                    rb <= ib[RW-1:SW];
                end
            end
        end else begin : g_out
            assign out_valid = rv;
            assign sum       = rps;
            assign cout      = rc;
`ifdef CSKIP_OVF_EN
            logic rov;

            // The carry into the MSB is recovered as a^b^sum at that bit.
            // Signed overflow is that carry XOR the carry-out.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    rov <= 1'b0;
                else if (en)
                    rov <= ia[RW-1] ^ ib[RW-1] ^ res[SW-1] ^ bc[BPS];
            end

            assign ovf = rov;
`endif
        end
    end

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_cskip_adder_pipe
// Directed and random checks of cskip_adder_pipe, configured with WIDTH=16,
// BLOCK=4 and STAGES=2.
// The bench keeps a cycle model of the pipeline valid bits and a queue of
// expected results.
// ---------------------------------------------------------------------------
module tb_cskip_adder_pipe;

    localparam int W   = 16;
    localparam int STG = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CSKIP_OVF_EN
    logic         ovf;
`endif

    int passed = 0;
    int checks = 0;

    logic [STG-1:0] mv;          // model valid bits, mv[STG-1] is the output slot
    logic [W+1:0]   q[$];        // expected {ovf, cout, sum}

    cskip_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(STG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSKIP_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        logic       v;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Compare the DUT against the model on the negative edge.
    // Then advance the model for the following rising edge.
    task automatic checkOutput();
        logic         men;
        logic [W+1:0] e;
        men = !mv[STG-1] || out_ready;
        chk("out_valid", {31'b0, out_valid}, {31'b0, mv[STG-1]});
        chk("in_ready", {31'b0, in_ready}, {31'b0, men});
        if (mv[STG-1]) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q[0];
                chk("sum", {16'b0, sum}, {16'b0, e[W-1:0]});
                chk("cout", {31'b0, cout}, {31'b0, e[W]});
`ifdef CSKIP_OVF_EN
                chk("ovf", {31'b0, ovf}, {31'b0, e[W+1]});
`endif
                if (out_ready)
                    void'(q.pop_front());
            end
        end
        if (men) begin
            mv = {mv[STG-2:0], in_valid};
            if (in_valid)
                q.push_back(calc(a, b, cin));
        end
    endtask

    // Drive one cycle of inputs, starting just after a rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic cc, input logic rdy);
        in_valid  = v;
        a         = aa;
        b         = bb;
        cin       = cc;
        out_ready = rdy;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++)
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("drain_remaining", q.size(), 32'd0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        mv        = '0;
        #2;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_sum", {16'b0, sum}, 32'd0);
        chk("reset_cout", {31'b0, cout}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Carry through every bit position; the result should be valid for exactly one cycle.
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Back-to-back operands, including a carry-in.
        applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
        drain();

        // Full-propagate operands take the all-skip path.
        applyStimulus(1'b1, 16'hF0F0, 16'h0F0F, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'hF0F0, 16'h0F0F, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
        drain();

        // Stall for four cycles once the first result is valid.
        applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        drain();

`ifdef CSKIP_OVF_EN
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
        drain();
`endif

        // Assert reset mid-cycle with two results in flight.
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1);
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midreset_sum", {16'b0, sum}, 32'd0);
        chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        mv = '0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b1);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                          1'($urandom), $urandom_range(0, 2) != 0);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cskip_adder_pipe.md
Name: cskip_adder_pipe

Overview:
- Parametrised, pipelined carry-skip adder. Successor to the fixed 16-bit carry-skip adder.
- Generalised in width, skip-block size and pipeline depth.
- Adds a valid/ready handshake with backpressure and a carry-in.
- Serves as the registered adder core for throughput and timing comparisons in the adder study benches.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of BLOCK.
- BLOCK, 4: carry-skip block size in bits.
- STAGES, 2: number of pipeline register stages, which is also the latency. (WIDTH/BLOCK) must be a multiple of STAGES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  adder accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  sum bits.
- cout  out  1  carry-out.
- ovf  out  1  signed overflow (present only with the macro).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous, active-low. While rst=0, every stage register clears immediately: out_valid=0, sum=0, cout=0, ovf=0, all internal valid bits 0.
  - in_ready=1 during and after reset (the pipeline is empty).
- Segmentation:
  - NB = WIDTH/BLOCK blocks. BPS = NB/STAGES blocks per stage.
  - Stage s (0..STAGES-1) adds bits [s*BPS*BLOCK +: BPS*BLOCK] combinationally from its input register (stage 0 from the ports), then registers into stage s+1.
  - Stage register contents: partial sum so far, carry, the unprocessed upper a/b bits, and valid.
  - Register STAGES is the output register.
- Carry-skip block:
  - Ripple carry inside the block.
  - Block propagate P = AND of (a_i XOR b_i) over the block.
  - Block carry-out = P ? block carry-in : ripple carry-out.
- Global enable:
  - en = !out_valid || out_ready. in_ready = en (combinational).
  - When en=1, all stage registers advance.
  - When en=0, all stage registers hold, including bubbles. No bubble collapsing.
- Transfers:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready.
- Latency:
  - A result accepted at edge k appears with out_valid=1 after edge k+STAGES-1, provided no stall occurs.
  - Each stall cycle adds one cycle.
  - Throughput is one result per cycle when out_ready=1.
- Result:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
  - a and b are registered at acceptance. Later port changes do not affect in-flight operations.
- Bubbles: in_valid=0 on an enabled edge inserts a bubble (valid=0). Its data is don't-care, but it must not raise out_valid.
- Boundary cases:
  - Full-propagate operands (a XOR b all ones) take the all-skip path and give the correct cout.
  - Simultaneous accept and output transfer in the same cycle is legal, with no loss or duplication.
  - rst asserted mid-operation discards all in-flight results. The first result after reset is the first operand accepted after release.
  - STAGES=1 gives a single output register. Latency is 1.

Optional Feature:
- Macro: CSKIP_OVF_EN.
- Defined: port ovf exists. ovf = carry into bit WIDTH-1 XOR cout, registered alongside sum. Cleared by reset.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package cskip_pkg:
  - Function cskip_nblocks(width, block).
  - Function cskip_bps(width, block, stages).
  - Elaboration-time checks for the divisibility rules. An illegal parameter set is a fatal error.
- Sub-module cskip_block: combinational BLOCK-bit ripple with skip multiplexer.
  - Inputs: a, b, ci.
  - Outputs: s, co.
  - Instantiated NB times across the stages.

Test Plan (WIDTH=16, BLOCK=4, STAGES=2 unless stated):
- a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> two cycles later sum=0x0000, cout=1, out_valid=1 for exactly one cycle.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Then a=0x8000, b=0x8000 on the next cycle -> sum=0x0000, cout=1 exactly one cycle after the first result.
- Three back-to-back operands (0x0001+0x0001, 0x00FF+0x0001, 0xFFFF+0xFFFF), out_ready=0 once the first result is valid, for 4 cycles:
  - in_ready=0 throughout the stall, outputs hold 0x0002.
  - After release: 0x0100, then sum=0xFFFE with cout=1, in order, none lost.
- Two operands in flight, then rst=0 for one cycle mid-clock -> out_valid=0 and sum=0 immediately. After release, no stale result emerges. A new 0x0003+0x0004 yields 0x0007.
- With CSKIP_OVF_EN defined: 0x7FFF+0x0001 -> sum=0x8000, ovf=1. 0xFFFF+0x0001 -> ovf=0, cout=1.
- WIDTH=32, BLOCK=4, STAGES=4, random 10^5 operand pairs with random out_ready -> every result equals the reference sum, in order, latency 4 when unstalled.
